freq_meter: RTL and testbench

Measures the frequency of a slow, clock-like signal using the 100 MHz system clock. It is the inverse of the clock divider: the divider turns a count into a toggling signal, and this block turns a toggling signal back into a count. It counts rising edges of an asynchronous input over a fixed gate window and reports the count with a one-cycle valid strobe. It is used on-board to self-check the divided clocks (1 Hz to 50 MHz) and as a general edge-rate monitor.

---
 rtl/freq_meter_pkg.sv | 15 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/freq_meter.sv | 119 +++++++++++
 tb/tb_freq_meter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        DONE
    } state_e;

    localparam int CLK_HZ          = 100_000_000;
    localparam int DEF_GATE_CYCLES = CLK_HZ;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level followed by a
// one-cycle rising-edge pulse generator.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("sync_edge_det: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Counts synchronized rising edges of sig_in over a fixed gate window and
// reports the count with a one-cycle valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic [CNT_W-1:0] freq_hz,
    output logic             freq_valid,
    output logic             overflow
);

    // The gate counter is widened when needed so a narrow result width can
    // still be paired with a long window.
    localparam int GATE_CLOG = $clog2(longint'(GATE_CYCLES) + 1);
    localparam int GATE_W    = (CNT_W > GATE_CLOG) ? CNT_W : GATE_CLOG;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 1) begin : g_bad_gate
        $error("freq_meter: GATE_CYCLES must be at least 1");
    end

    // Returns {edge_lost, next_count}; the count sticks at all-ones.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             inc);
        if (inc && (&cnt)) begin
            return {1'b1, cnt};
        end
        return {1'b0, cnt + CNT_W'(inc)};
    endfunction

    logic              rise;
    state_e            state_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_d;
    logic              edge_lost_d;
    logic              ovf_int_q;
    logic [CNT_W-1:0]  freq_hz_q;
    logic              overflow_q;
    logic              freq_valid_q;
    logic              busy_q;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(sig_in),
        .rise_o (rise)
    );

    assign {edge_lost_d, edge_cnt_d} = sat_inc(edge_cnt_q, rise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            ovf_int_q    <= 1'b0;
            freq_hz_q    <= '0;
            overflow_q   <= 1'b0;
            freq_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    gate_cnt_q <= '0;
                    edge_cnt_q <= '0;
                    ovf_int_q  <= 1'b0;
                    state_q    <= MEASURE;
                end
                MEASURE: begin
                    gate_cnt_q <= gate_cnt_q + GATE_W'(1);
                    edge_cnt_q <= edge_cnt_d;
                    ovf_int_q  <= ovf_int_q | edge_lost_d;
                    // Capture with the last cycle's edge folded in so the
                    // result is already stable while freq_valid is high.
                    if (gate_cnt_q == GATE_LAST) begin
                        freq_hz_q    <= edge_cnt_d;
                        overflow_q   <= ovf_int_q | edge_lost_d;
                        freq_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (continuous) begin
                        state_q <= ARM;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign freq_hz    = freq_hz_q;
    assign freq_valid = freq_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: table vectors, boundary/corner sequences and random
// input windows checked against an edge-counting reference model.
module tb_freq_meter;

    localparam int GA   = 100;
    localparam int WA   = 16;
    localparam int MAXA = (1 << WA) - 1;
    localparam int GS   = 200;
    localparam int WS   = 4;
    localparam int NTR  = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sig_a = 1'b0, start_a = 1'b0, cont_a = 1'b0;
    logic          busy_a, valid_a, ovf_a;
    logic [WA-1:0] freq_a;
    logic          sig_s = 1'b0, start_s = 1'b0, cont_s = 1'b0;
    logic          busy_s, valid_s, ovf_s;
    logic [WS-1:0] freq_s;

    freq_meter #(.GATE_CYCLES(GA), .CNT_W(WA), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_a), .start(start_a),
        .continuous(cont_a), .busy(busy_a), .freq_hz(freq_a),
        .freq_valid(valid_a), .overflow(ovf_a)
    );

    freq_meter #(.GATE_CYCLES(GS), .CNT_W(WS), .SYNC_STAGES(2)) u_s (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_s), .start(start_s),
        .continuous(cont_s), .busy(busy_s), .freq_hz(freq_s),
        .freq_valid(valid_s), .overflow(ovf_s)
    );

    always #5 clk = ~clk;

    // cyc is the index of the next posedge; inputs set now are sampled there.
    int cyc = 0;
    bit tr_sig[NTR];
    bit tr_cont[NTR];

    always @(posedge clk) begin
        if (cyc < NTR) begin
            tr_sig[cyc]  = sig_a;
            tr_cont[cyc] = cont_a;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    int pend[$];
    int done_edge = -1;
    int n_valid = 0;
    int last_vcyc = -1;
    int last_freq = 0;
    int last_ovf = 0;

    int gen_a = 0;
    int half_a = 5;
    int run_a = 5;
    bit gen_s = 1'b0;
    int run_s = 2;

    typedef struct {
        int half;
        int offset;
        int exp_cnt;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // A window whose start is sampled at posedge p counts every rise of sig_in
    // first seen at posedges p .. p+GA-1 (two synchronizer cycles of delay).
    function automatic int model_count(input int p);
        int n;
        n = 0;
        for (int m = p; m <= p + GA - 1; m++) begin
            if (tr_sig[m] && !tr_sig[m-1]) n++;
        end
        return n;
    endfunction

    task automatic step();
        int p;
        int exp_n;
        @(negedge clk);
        cyc++;
        if (cyc >= NTR - 2) begin
            $display("FAIL trace_space: cycle %0d, limit %0d", cyc, NTR);
            $fatal(1, "bench trace space exhausted");
        end
        if (done_edge >= 0 && cyc == done_edge + 1) begin
            if (tr_cont[done_edge]) pend.push_back(done_edge);
            done_edge = -1;
        end
        if (valid_a) begin
            n_valid++;
            last_vcyc = cyc;
            last_freq = int'(freq_a);
            last_ovf  = int'(ovf_a);
            if (pend.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                p = pend.pop_front();
                exp_n = model_count(p);
                chk("model_latency", cyc - p, GA + 2);
                chk("model_freq", freq_a, (exp_n > MAXA) ? MAXA : exp_n);
                chk("model_ovf", ovf_a, (exp_n > MAXA) ? 1 : 0);
                chk("busy_in_done", busy_a, 1);
                done_edge = cyc;
            end
        end else if (pend.size() != 0 && cyc > pend[0] + GA + 2) begin
            chk("missing_valid", 0, 1);
            void'(pend.pop_front());
        end
        if (gen_a != 0) begin
            if (run_a > 1) run_a--;
            else begin
                sig_a = ~sig_a;
                run_a = (gen_a == 1) ? half_a : int'($urandom_range(2, 6));
            end
        end
        if (gen_s) begin
            if (run_s > 1) run_s--;
            else begin
                sig_s = ~sig_s;
                run_s = 2;
            end
        end
    endtask

    task automatic pulse_start_a();
        if (pend.size() == 0 && done_edge < 0) pend.push_back(cyc);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic wait_valid_a(input int budget);
        int v0;
        v0 = n_valid;
        for (int i = 0; i < budget && n_valid == v0; i++) step();
        if (n_valid == v0) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic edge_window(input int rise_off, input int exp_cnt, input string name);
        int p;
        sig_a = 1'b0;
        gen_a = 0;
        repeat (4) step();
        p = cyc + 3;
        for (int k = 0; k < GA + 8; k++) begin
            if (cyc == p + rise_off) sig_a = 1'b1;
            if (cyc == p) pulse_start_a();
            else step();
        end
        chk({name, "_latency"}, last_vcyc - p, GA + 2);
        chk(name, last_freq, exp_cnt);
        sig_a = 1'b0;
        repeat (3) step();
    endtask

    task automatic sat_window(input int exp_freq, input int exp_ovf);
        int ps;
        bit got;
        got = 1'b0;
        start_s = 1'b1;
        ps = cyc;
        step();
        start_s = 1'b0;
        for (int i = 0; i < GS + 10; i++) begin
            step();
            if (valid_s) begin
                got = 1'b1;
                break;
            end
        end
        chk("sat_seen", got, 1);
        chk("sat_latency", cyc - ps, GS + 2);
        chk("sat_freq", freq_s, exp_freq);
        chk("sat_ovf", ovf_s, exp_ovf);
        repeat (3) step();
        chk("sat_busy_idle", busy_s, 0);
        chk("sat_hold", freq_s, exp_freq);
    endtask

    initial begin
        int pc;
        int prev;
        int v0;

        for (int off = 0; off < 10; off++) vecs.push_back('{5, off, 10});
        vecs.push_back('{2, 0, 25});
        vecs.push_back('{2, 3, 25});
        vecs.push_back('{10, 7, 5});
        vecs.push_back('{25, 11, 2});

        // Reset state
        repeat (3) step();
        chk("rst_busy", busy_a, 0);
        chk("rst_freq", freq_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_freq_s", freq_s, 0);
        rst_n = 1'b1;
        repeat (3) step();

        // Table: periodic inputs at several phase offsets
        foreach (vecs[i]) begin
            sig_a  = 1'b0;
            gen_a  = 1;
            half_a = vecs[i].half;
            run_a  = vecs[i].half;
            repeat (vecs[i].offset + 4) step();
            pc = cyc;
            pulse_start_a();
            wait_valid_a(GA + 10);
            chk("tbl_latency", last_vcyc - pc, GA + 2);
            chk("tbl_freq", last_freq, vecs[i].exp_cnt);
            chk("tbl_ovf", last_ovf, 0);
            step();
            chk("tbl_busy_idle", busy_a, 0);
            repeat (2) step();
        end

        // Single edges around the window boundaries
        edge_window(-1, 0, "edge_in_arm");
        edge_window(0, 1, "edge_first_measure");
        edge_window(GA - 1, 1, "edge_last_measure");
        edge_window(GA, 0, "edge_in_done");

        // Random inputs, some windows with an ignored start mid-measurement
        gen_a = 2;
        run_a = 3;
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(3, 20)) step();
            v0 = n_valid;
            pulse_start_a();
            if (r % 3 == 1) begin
                repeat ($urandom_range(5, 60)) step();
                pulse_start_a();
            end
            wait_valid_a(GA + 10);
            chk("rnd_one_valid", n_valid - v0, 1);
            step();
            chk("rnd_busy_idle", busy_a, 0);
        end

        // Start while busy: one result only
        v0 = n_valid;
        pulse_start_a();
        repeat (30) step();
        chk("busy_measure", busy_a, 1);
        pulse_start_a();
        repeat (GA + 60) step();
        chk("busy_start_one_valid", n_valid - v0, 1);

        // Continuous mode, then drop continuous mid-window
        gen_a  = 1;
        half_a = 2;
        run_a  = 2;
        sig_a  = 1'b0;
        repeat (5) step();
        cont_a = 1'b1;
        pulse_start_a();
        prev = -1;
        for (int w = 0; w < 4; w++) begin
            wait_valid_a(GA + 10);
            chk("cont_freq", last_freq, 25);
            if (prev >= 0) chk("cont_spacing", last_vcyc - prev, GA + 2);
            prev = last_vcyc;
        end
        repeat (30) step();
        cont_a = 1'b0;
        wait_valid_a(GA + 10);
        chk("cont_last_freq", last_freq, 25);
        chk("cont_last_spacing", last_vcyc - prev, GA + 2);
        step();
        chk("cont_busy_off", busy_a, 0);
        v0 = n_valid;
        repeat (GA + 20) step();
        chk("cont_no_extra", n_valid - v0, 0);

        // Reset mid-measurement
        gen_a = 2;
        pulse_start_a();
        repeat (40) step();
        rst_n = 1'b0;
        pend.delete();
        done_edge = -1;
        step();
        chk("midrst_busy", busy_a, 0);
        chk("midrst_freq", freq_a, 0);
        chk("midrst_valid", valid_a, 0);
        chk("midrst_ovf", ovf_a, 0);
        repeat (4) step();
        rst_n = 1'b1;
        v0 = n_valid;
        repeat (GA + 20) step();
        chk("midrst_no_valid", n_valid - v0, 0);
        chk("midrst_busy_after", busy_a, 0);
        gen_a = 0;
        sig_a = 1'b0;

        // Saturation on the narrow instance, then a quiet window
        gen_s = 1'b1;
        run_s = 2;
        sig_s = 1'b0;
        repeat (5) step();
        sat_window(15, 1);
        gen_s = 1'b0;
        sig_s = 1'b0;
        repeat (5) step();
        sat_window(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
